// File: rtl/admm_dual_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : admm_dual_sequencer_if
// Description : Bundles the host command, horizon-buffer read, dual-update
//               datapath and write-back signals of the ADMM dual sequencer.
//               master = sequencer side, slave = host/buffer/datapath side.
// Ports       : none (clk/reset stay plain ports on the modules)
//   cmd_*      host start/abort/busy/done, primal_res residual result
//   rd_*       horizon-buffer read request/response
//   du_*       dual-update datapath launch/operands/results
//   wr_*       horizon-buffer write-back with ready handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface admm_dual_sequencer_if #(
   parameter int CONTROL_DIM = 4,
   parameter int STATE_DIM   = 12,
   parameter int W           = 16,
   parameter int IDX_W       = 4
);
   logic                         cmd_start;
   logic                         cmd_abort;
   logic                         cmd_busy;
   logic                         cmd_done;
   logic [W-1:0]                 primal_res;

   logic                         rd_en;
   logic [IDX_W-1:0]             rd_idx;
   logic                         rd_valid;
   logic [3*W*CONTROL_DIM-1:0]   rd_ctrl;
   logic [3*W*STATE_DIM-1:0]     rd_state;

   logic                         du_start;
   logic [3*W*CONTROL_DIM-1:0]   du_ctrl;
   logic [3*W*STATE_DIM-1:0]     du_state;
   logic                         du_done;
   logic [W*CONTROL_DIM-1:0]     du_y;
   logic [W*STATE_DIM-1:0]       du_g;

   logic                         wr_en;
   logic [IDX_W-1:0]             wr_idx;
   logic [W*CONTROL_DIM-1:0]     wr_y;
   logic [W*STATE_DIM-1:0]       wr_g;
   logic                         wr_ready;

   modport master (
      input  cmd_start, cmd_abort, rd_valid, rd_ctrl, rd_state,
             du_done, du_y, du_g, wr_ready,
      output cmd_busy, cmd_done, primal_res, rd_en, rd_idx,
             du_start, du_ctrl, du_state, wr_en, wr_idx, wr_y, wr_g
   );

   modport slave (
      output cmd_start, cmd_abort, rd_valid, rd_ctrl, rd_state,
             du_done, du_y, du_g, wr_ready,
      input  cmd_busy, cmd_done, primal_res, rd_en, rd_idx,
             du_start, du_ctrl, du_state, wr_en, wr_idx, wr_y, wr_g
   );
endinterface
`default_nettype wire

// File: rtl/admm_dual_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : admm_dual_sequencer
// Description : Walks the MPC horizon k = 0..HORIZON-1. Per timestep it reads
//               primal/slack/dual vectors, launches one dual update, captures
//               the updated duals and writes them back. Tracks the max-abs
//               primal residual over the sweep for the convergence check.
// Ports       :
//   clk        clock
//   reset      asynchronous active-high reset
//   bus        admm_dual_sequencer_if.master (cmd_*, rd_*, du_*, wr_*)
// Revision    : 1.0 - initial release
// ============================================================================
module admm_dual_sequencer #(
   parameter int CONTROL_DIM = 4,
   parameter int STATE_DIM   = 12,
   parameter int W           = 16,
   parameter int HORIZON     = 10,
   parameter int IDX_W       = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   admm_dual_sequencer_if.master  bus
);

   localparam int               c_ctrl_w   = 3 * W * CONTROL_DIM;
   localparam int               c_state_w  = 3 * W * STATE_DIM;
   localparam int               c_y_w      = W * CONTROL_DIM;
   localparam int               c_g_w      = W * STATE_DIM;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(HORIZON - 1);
   localparam logic [W-1:0]     c_sat      = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_WAIT_RD = 3'd2,
      S_COMPUTE = 3'd3,
      S_WAIT_DU = 3'd4,
      S_WRITE   = 3'd5,
      S_FINISH  = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [IDX_W-1:0]      r_idx;
   logic [W-1:0]          r_max;
   logic [W-1:0]          r_primal_res;
   logic [c_ctrl_w-1:0]   r_op_ctrl;
   logic [c_state_w-1:0]  r_op_state;
   logic [c_y_w-1:0]      r_wr_y;
   logic [c_g_w-1:0]      r_wr_g;

   logic                  w_sweep_clr;
   logic                  w_latch_ops;
   logic                  w_latch_res;
   logic                  w_idx_inc;
   logic                  w_publish;
   logic [W-1:0]          w_elem;
   logic [W-1:0]          w_fold_max;

   // |a-b| computed one bit wider so the difference cannot wrap, then clamped
   // to the largest positive W-bit value.
   function automatic logic [W-1:0] abs_sat(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W:0] diff;
      logic [W:0] mag;
      diff = {a[W-1], a} - {b[W-1], b};
      mag  = diff[W] ? (~diff + (W+1)'(1)) : diff;
      return (mag > {1'b0, c_sat}) ? c_sat : mag[W-1:0];
   endfunction

   // Running max folded with every |u-z| and |x-v| of the incoming read data.
   always_comb begin
      w_fold_max = r_max;
      w_elem     = '0;
      for (int i = 0; i < CONTROL_DIM; i++) begin
         w_elem = abs_sat(bus.rd_ctrl[i*W +: W],
                          bus.rd_ctrl[(CONTROL_DIM+i)*W +: W]);
         if (w_elem > w_fold_max) w_fold_max = w_elem;
      end
      for (int i = 0; i < STATE_DIM; i++) begin
         w_elem = abs_sat(bus.rd_state[i*W +: W],
                          bus.rd_state[(STATE_DIM+i)*W +: W]);
         if (w_elem > w_fold_max) w_fold_max = w_elem;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Abort overrides every other transition; in IDLE it also suppresses a
   // simultaneous start so the two together leave the block idle.
   always_comb begin
      w_next      = r_state;
      w_sweep_clr = 1'b0;
      w_latch_ops = 1'b0;
      w_latch_res = 1'b0;
      w_idx_inc   = 1'b0;
      w_publish   = 1'b0;
      if ((r_state != S_IDLE) && bus.cmd_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_start && !bus.cmd_abort) begin
                  w_next      = S_READ;
                  w_sweep_clr = 1'b1;
               end
            end
            S_READ: begin
               w_next = S_WAIT_RD;
            end
            S_WAIT_RD: begin
               if (bus.rd_valid) begin
                  w_next      = S_COMPUTE;
                  w_latch_ops = 1'b1;
               end
            end
            S_COMPUTE: begin
               w_next = S_WAIT_DU;
            end
            S_WAIT_DU: begin
               if (bus.du_done) begin
                  w_next      = S_WRITE;
                  w_latch_res = 1'b1;
               end
            end
            S_WRITE: begin
               if (bus.wr_ready) begin
                  if (r_idx == c_last_idx) begin
                     w_next = S_FINISH;
                  end else begin
                     w_next    = S_READ;
                     w_idx_inc = 1'b1;
                  end
               end
            end
            S_FINISH: begin
               w_next    = S_IDLE;
               w_publish = 1'b1;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx        <= '0;
         r_max        <= '0;
         r_primal_res <= '0;
         r_op_ctrl    <= '0;
         r_op_state   <= '0;
         r_wr_y       <= '0;
         r_wr_g       <= '0;
      end else begin
         if (w_sweep_clr) begin
            r_idx <= '0;
            r_max <= '0;
         end
         if (w_idx_inc) begin
            r_idx <= r_idx + IDX_W'(1);
         end
         if (w_latch_ops) begin
            r_op_ctrl  <= bus.rd_ctrl;
            r_op_state <= bus.rd_state;
            r_max      <= w_fold_max;
         end
         if (w_latch_res) begin
            r_wr_y <= bus.du_y;
            r_wr_g <= bus.du_g;
         end
         if (w_publish) begin
            r_primal_res <= r_max;
         end
      end
   end

   assign bus.cmd_busy   = (r_state != S_IDLE);
   assign bus.cmd_done   = (r_state == S_FINISH);
   assign bus.primal_res = r_primal_res;
   assign bus.rd_en      = (r_state == S_READ);
   assign bus.rd_idx     = r_idx;
   assign bus.du_start   = (r_state == S_COMPUTE);
   assign bus.du_ctrl    = r_op_ctrl;
   assign bus.du_state   = r_op_state;
   assign bus.wr_en      = (r_state == S_WRITE);
   assign bus.wr_idx     = r_idx;
   assign bus.wr_y       = r_wr_y;
   assign bus.wr_g       = r_wr_g;

endmodule
`default_nettype wire

// File: tb/tb_admm_dual_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_admm_dual_sequencer
// Description : Self-checking bench for admm_dual_sequencer. Emulates the
//               horizon buffer and dual-update datapath with configurable
//               per-timestep delays, and checks sweep ordering, operand and
//               write-back data, timing and the primal residual against a
//               plain-arithmetic reference.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_admm_dual_sequencer;

   localparam int CONTROL_DIM = 4;
   localparam int STATE_DIM   = 12;
   localparam int W           = 16;
   localparam int HORIZON     = 10;
   localparam int IDX_W       = 4;
   localparam int CW          = 3 * W * CONTROL_DIM;
   localparam int SW          = 3 * W * STATE_DIM;
   localparam int YW          = W * CONTROL_DIM;
   localparam int GW          = W * STATE_DIM;
   localparam int TIMEOUT     = 2000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   admm_dual_sequencer_if #(
      .CONTROL_DIM(CONTROL_DIM), .STATE_DIM(STATE_DIM), .W(W), .IDX_W(IDX_W)
   ) bus ();

   admm_dual_sequencer #(
      .CONTROL_DIM(CONTROL_DIM), .STATE_DIM(STATE_DIM), .W(W),
      .HORIZON(HORIZON), .IDX_W(IDX_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int mode;       // 0 zero, 1 spot values, 2 saturation, 3 small random, 4 full random
      int dly_kind;   // 0 zero-wait, 1 idx5 rd+3 / stall 4, 2 random delays
      bit spur;       // spurious du_done / cmd_start while waiting for read data
      int exp_done;   // expected done edge, -1 = from reference model
      int exp_res;    // expected primal_res, -1 = from reference model
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [CW-1:0] mem_ctrl  [HORIZON];
   logic [SW-1:0] mem_state [HORIZON];
   logic [YW-1:0] exp_y     [HORIZON];
   logic [GW-1:0] exp_g     [HORIZON];
   int rd_dly   [HORIZON];
   int du_dly   [HORIZON];
   int wr_stall [HORIZON];
   int abort_at;
   bit spurious;

   int done_cnt, done_edge, end_edge, abort_edge, du_starts;
   int rd_order[$];
   int wr_order[$];
   bit ops_ok, wr_ok;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [SW-1:0] rnd_wide();
      logic [SW-1:0] r;
      for (int i = 0; i < SW; i++) r[i] = 1'($urandom);
      return r;
   endfunction

   function automatic bit seq_ok(input int q[$]);
      if (q.size() != HORIZON) return 1'b0;
      for (int i = 0; i < HORIZON; i++) if (q[i] != i) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: largest saturated |u-z| or |x-v| over the whole horizon.
   function automatic int ref_residual();
      int m, a, b, d, sat;
      m   = 0;
      sat = (1 << (W - 1)) - 1;
      for (int t = 0; t < HORIZON; t++) begin
         for (int i = 0; i < CONTROL_DIM; i++) begin
            a = int'($signed(mem_ctrl[t][i*W +: W]));
            b = int'($signed(mem_ctrl[t][(CONTROL_DIM+i)*W +: W]));
            d = (a > b) ? a - b : b - a;
            if (d > sat) d = sat;
            if (d > m) m = d;
         end
         for (int i = 0; i < STATE_DIM; i++) begin
            a = int'($signed(mem_state[t][i*W +: W]));
            b = int'($signed(mem_state[t][(STATE_DIM+i)*W +: W]));
            d = (a > b) ? a - b : b - a;
            if (d > sat) d = sat;
            if (d > m) m = d;
         end
      end
      return m;
   endfunction

   function automatic int ref_done_edge();
      int s;
      s = 5 * HORIZON;
      for (int t = 0; t < HORIZON; t++) s += rd_dly[t] + du_dly[t] + wr_stall[t];
      return s;
   endfunction

   task automatic idle_inputs();
      bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0;
      bus.rd_valid  = 1'b0; bus.rd_ctrl   = '0; bus.rd_state = '0;
      bus.du_done   = 1'b0; bus.du_y      = '0; bus.du_g     = '0;
      bus.wr_ready  = 1'b0;
   endtask

   task automatic fill(input int mode, input int dly_kind);
      logic [SW-1:0] r;
      for (int t = 0; t < HORIZON; t++) begin
         mem_ctrl[t]  = '0;
         mem_state[t] = '0;
         r = rnd_wide(); exp_y[t] = r[YW-1:0];
         r = rnd_wide(); exp_g[t] = r[GW-1:0];
         rd_dly[t] = 0; du_dly[t] = 0; wr_stall[t] = 0;
         if (mode == 3) begin
            for (int e = 0; e < 3*CONTROL_DIM; e++)
               mem_ctrl[t][e*W +: W] = W'($urandom_range(0, 4095) - 2048);
            for (int e = 0; e < 3*STATE_DIM; e++)
               mem_state[t][e*W +: W] = W'($urandom_range(0, 4095) - 2048);
         end else if (mode == 4) begin
            r = rnd_wide(); mem_ctrl[t] = r[CW-1:0];
            mem_state[t] = rnd_wide();
         end
         if (dly_kind == 2) begin
            rd_dly[t]   = $urandom_range(0, 2);
            du_dly[t]   = $urandom_range(0, 2);
            wr_stall[t] = $urandom_range(0, 2);
         end
      end
      if (mode == 1) begin
         mem_ctrl[3][2*W +: W]                 = 16'h0100;
         mem_ctrl[3][(CONTROL_DIM+2)*W +: W]   = 16'h0040;
         mem_state[7][5*W +: W]                = 16'hFF00;
         mem_state[7][(STATE_DIM+5)*W +: W]    = 16'h0010;
      end else if (mode == 2) begin
         mem_ctrl[0][0 +: W]                   = 16'h7FFF;
         mem_ctrl[0][CONTROL_DIM*W +: W]       = 16'h8000;
      end
      if (dly_kind == 1) begin
         rd_dly[5]   = 3;
         wr_stall[5] = 4;
      end
   endtask

   // Cycle-level environment: observes the DUT at each falling edge and
   // drives buffer/datapath responses for the next rising edge.
   task automatic run_sweep();
      bit rd_pend, du_pend, wr_act, abort_arm;
      int rd_cnt, du_cnt, wr_cnt, cur_rd, cur_du;
      logic [SW-1:0] junk;
      rd_order.delete(); wr_order.delete();
      done_cnt = 0; done_edge = -1; end_edge = -1; abort_edge = -1; du_starts = 0;
      ops_ok = 1'b1; wr_ok = 1'b1;
      rd_pend = 0; du_pend = 0; wr_act = 0; abort_arm = 0;
      rd_cnt = 0; du_cnt = 0; wr_cnt = 0; cur_rd = 0; cur_du = 0;
      @(negedge clk); bus.cmd_start = 1'b1;
      @(negedge clk); bus.cmd_start = 1'b0;
      for (int e = 0; e < TIMEOUT; e++) begin
         junk = rnd_wide();
         bus.rd_valid = 1'b0; bus.du_done = 1'b0; bus.wr_ready = 1'b0;
         bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0;
         bus.rd_ctrl = junk[CW-1:0]; bus.rd_state = junk;
         if (!bus.cmd_busy) begin
            end_edge = e;
            break;
         end
         if (bus.cmd_done) begin
            done_cnt++;
            done_edge = e;
         end
         if (bus.rd_en) begin
            rd_order.push_back(int'(bus.rd_idx));
            cur_rd  = int'(bus.rd_idx) % HORIZON;
            rd_pend = 1'b1;
            rd_cnt  = rd_dly[cur_rd];
         end else if (rd_pend) begin
            if (rd_cnt == 0) begin
               bus.rd_valid = 1'b1;
               bus.rd_ctrl  = mem_ctrl[cur_rd];
               bus.rd_state = mem_state[cur_rd];
               rd_pend      = 1'b0;
            end else begin
               rd_cnt--;
            end
            if (spurious) begin
               bus.du_done   = 1'b1;
               bus.cmd_start = 1'b1;
            end
         end
         if (bus.du_start) begin
            du_starts++;
            cur_du  = cur_rd;
            du_pend = 1'b1;
            du_cnt  = du_dly[cur_du];
            if (cur_du == abort_at) abort_arm = 1'b1;
         end else if (du_pend) begin
            if (abort_arm) begin
               bus.cmd_abort = 1'b1;
               abort_edge    = e;
               du_pend       = 1'b0;
            end else if (du_cnt == 0) begin
               bus.du_done = 1'b1;
               bus.du_y    = exp_y[cur_du];
               bus.du_g    = exp_g[cur_du];
               du_pend     = 1'b0;
            end else begin
               du_cnt--;
            end
         end
         if (bus.du_start || du_pend || bus.wr_en) begin
            if (bus.du_ctrl !== mem_ctrl[cur_du] || bus.du_state !== mem_state[cur_du])
               ops_ok = 1'b0;
         end
         if (bus.wr_en) begin
            if (!wr_act) begin
               wr_act = 1'b1;
               wr_order.push_back(int'(bus.wr_idx));
               wr_cnt = wr_stall[cur_du];
            end
            if (bus.wr_idx !== IDX_W'(cur_du) || bus.wr_y !== exp_y[cur_du] ||
                bus.wr_g !== exp_g[cur_du])
               wr_ok = 1'b0;
            if (wr_cnt == 0) begin
               bus.wr_ready = 1'b1;
               wr_act       = 1'b0;
            end else begin
               wr_cnt--;
            end
         end
         @(negedge clk);
      end
      check("sweep_terminates", end_edge >= 0, 1);
      if (end_edge < 0) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
      end
      idle_inputs();
   endtask

   task automatic eval_normal(input string tag, input int exp_done, input int exp_res);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_done_edge"}, done_edge, exp_done);
      check({tag, "_busy_fall_edge"}, end_edge, exp_done + 1);
      check({tag, "_du_starts"}, du_starts, HORIZON);
      check({tag, "_read_order"}, seq_ok(rd_order), 1);
      check({tag, "_write_order"}, seq_ok(wr_order), 1);
      check({tag, "_operands"}, ops_ok, 1);
      check({tag, "_write_data"}, wr_ok, 1);
      check({tag, "_primal_res"}, bus.primal_res, exp_res);
   endtask

   vec_t tbl [8];

   initial begin
      int ed, er;
      tbl[0] = '{0, 0, 1'b0, 50, 0};
      tbl[1] = '{1, 0, 1'b0, 50, 'h0110};
      tbl[2] = '{2, 0, 1'b0, 50, 'h7FFF};
      tbl[3] = '{0, 1, 1'b0, 57, 0};
      tbl[4] = '{0, 0, 1'b1, 50, 0};
      tbl[5] = '{3, 2, 1'b0, -1, -1};
      tbl[6] = '{3, 2, 1'b1, -1, -1};
      tbl[7] = '{4, 0, 1'b0, 50, -1};

      abort_at = -1;
      spurious = 1'b0;
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy",       bus.cmd_busy, 0);
      check("rst_done",       bus.cmd_done, 0);
      check("rst_rd_en",      bus.rd_en, 0);
      check("rst_du_start",   bus.du_start, 0);
      check("rst_wr_en",      bus.wr_en, 0);
      check("rst_primal_res", bus.primal_res, 0);
      check("rst_idx",        {bus.rd_idx, bus.wr_idx}, 0);
      check("rst_regs_zero",  |{bus.du_ctrl, bus.du_state, bus.wr_y, bus.wr_g}, 0);
      reset = 1'b0;

      // Spurious handshakes in IDLE, then start together with abort.
      @(negedge clk);
      bus.du_done = 1'b1; bus.rd_valid = 1'b1; bus.wr_ready = 1'b1; bus.cmd_abort = 1'b1;
      @(negedge clk);
      check("idle_spurious_busy", bus.cmd_busy, 0);
      check("idle_spurious_du_start", bus.du_start, 0);
      idle_inputs();
      bus.cmd_start = 1'b1; bus.cmd_abort = 1'b1;
      @(negedge clk);
      check("start_with_abort_busy", bus.cmd_busy, 0);
      idle_inputs();

      for (int r = 0; r < 8; r++) begin
         fill(tbl[r].mode, tbl[r].dly_kind);
         spurious = tbl[r].spur;
         ed = (tbl[r].exp_done < 0) ? ref_done_edge() : tbl[r].exp_done;
         er = (tbl[r].exp_res  < 0) ? ref_residual()  : tbl[r].exp_res;
         run_sweep();
         eval_normal($sformatf("row%0d", r), ed, er);
      end
      spurious = 1'b0;

      // Known residual, then an aborted sweep must leave it untouched.
      fill(1, 0);
      run_sweep();
      eval_normal("pre_abort", 50, 'h0110);
      fill(3, 2);
      abort_at = 2;
      run_sweep();
      abort_at = -1;
      check("abort_no_done", done_cnt, 0);
      check("abort_busy_drop", end_edge, abort_edge + 1);
      check("abort_reads", rd_order.size(), 3);
      check("abort_writes", wr_order.size(), 2);
      check("abort_primal_res", bus.primal_res, 'h0110);

      // Reset in the middle of a sweep.
      fill(3, 0);
      @(negedge clk); bus.cmd_start = 1'b1;
      @(negedge clk); bus.cmd_start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_busy", bus.cmd_busy, 0);
      check("midrst_strobes", {bus.rd_en, bus.du_start, bus.wr_en, bus.cmd_done}, 0);
      check("midrst_primal_res", bus.primal_res, 0);
      check("midrst_regs_zero", |{bus.du_ctrl, bus.du_state, bus.wr_y, bus.wr_g, bus.rd_idx}, 0);
      @(negedge clk);
      reset = 1'b0;

      // Fresh sweep after the abort/reset restarts from timestep 0.
      fill(2, 0);
      run_sweep();
      eval_normal("restart", 50, 'h7FFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/admm_dual_sequencer.md
Name: admm_dual_sequencer

Overview:
Sequences the ADMM dual-update datapath across the MPC horizon. For each timestep k = 0..HORIZON-1 the block:
- fetches that timestep's primal, slack and dual vectors from the horizon buffer;
- launches one dual-update operation and captures the updated duals;
- writes the updated duals back to the buffer.

It also accumulates the primal residual (max-abs) for the outer convergence check. It sits between the host-facing ADMM control registers and the dual-update datapath.

Parameters:
CONTROL_DIM, 4, control vector length
STATE_DIM, 12, state vector length
W, 16, signed fixed-point element width
HORIZON, 10, timesteps per sweep (>=1)
IDX_W, 4, timestep index width (>= clog2(HORIZON))

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
cmd_start  in  1  begin sweep (sampled in IDLE only)
cmd_abort  in  1  synchronous abort of sweep in progress
cmd_busy  out  1  high in any state other than IDLE
cmd_done  out  1  one-cycle pulse at sweep completion
primal_res  out  W  unsigned max |u-z|,|x-v| over last completed sweep
rd_en  out  1  buffer read request (one cycle)
rd_idx  out  IDX_W  timestep index of read
rd_valid  in  1  read data valid
rd_ctrl  in  3*W*CONTROL_DIM  {y,z,u}, u at LSBs
rd_state  in  3*W*STATE_DIM  {g,v,x}, x at LSBs
du_start  out  1  datapath launch pulse
du_ctrl  out  3*W*CONTROL_DIM  latched {y,z,u} operands
du_state  out  3*W*STATE_DIM  latched {g,v,x} operands
du_done  in  1  datapath result valid
du_y  in  W*CONTROL_DIM  updated y
du_g  in  W*STATE_DIM  updated g
wr_en  out  1  write-back request, held until accepted
wr_idx  out  IDX_W  timestep index of write
wr_y  out  W*CONTROL_DIM  latched du_y
wr_g  out  W*STATE_DIM  latched du_g
wr_ready  in  1  buffer accepts write when high with wr_en

Behaviour:
- Reset: state IDLE. All outputs, operand/result registers and index are 0; primal_res=0.
- States and transitions:
  - IDLE: cmd_start -> READ. Set idx=0 and running max=0.
  - READ: rd_en=1 and rd_idx=idx for exactly this cycle -> WAIT_RD.
  - WAIT_RD: on rd_valid, latch rd_ctrl/rd_state into operand registers and fold residual -> COMPUTE. Otherwise hold.
  - COMPUTE: du_start=1 for exactly this cycle -> WAIT_DU.
  - WAIT_DU: on du_done, latch du_y/du_g into wr_y/wr_g -> WRITE.
  - WRITE: wr_en=1, wr_idx=idx. On wr_ready: if idx==HORIZON-1 -> FINISH, else idx++ and -> READ.
  - FINISH: cmd_done=1; primal_res <= running max -> IDLE.
- du_ctrl/du_state are driven continuously from the operand registers and are stable from COMPUTE until the next rd_valid latch.
- rd_valid is ignored outside WAIT_RD; du_done is ignored outside WAIT_DU. cmd_start is ignored while busy.
- Residual: for each element compute d = a-b at W+1 bits, then |d|, saturated to 2^(W-1)-1 (e.g. 7FFF for W=16). Running max takes the max over all elements of u-z and x-v for every timestep.
- Zero-wait latency (rd_valid 1 cycle after rd_en, du_done 1 cycle after du_start, wr_ready high):
  - 5 cycles per timestep;
  - cmd_done is high in the cycle after clock edge 5*HORIZON, counted from the edge that sampled cmd_start (edge 0);
  - cmd_busy is high from edge 0 through edge 5*HORIZON+1.
- cmd_abort in any non-IDLE state -> IDLE at the next edge:
  - no cmd_done;
  - primal_res unchanged;
  - wr_en drops immediately at that edge, and an unaccepted write is discarded.
- cmd_abort takes priority over every other transition. cmd_abort in IDLE has no effect, and cmd_start+cmd_abort together in IDLE -> stay IDLE.
- Reset mid-sweep returns to IDLE with all outputs cleared; primal_res is cleared.
- wr_ready low stalls WRITE indefinitely, with wr_en/wr_idx/wr_y/wr_g held stable.

Test Plan:
- HORIZON=10, zero-wait models, u=z=x=v=0 -> 10 reads idx 0..9 in order, 10 writes idx 0..9, cmd_done on the cycle after edge 50, primal_res=0.
- idx 3: u[2]=0x0100, z[2]=0x0040; idx 7: x[5]=0xFF00(-256), v[5]=0x0010; all else 0 -> primal_res=0x0110 after done.
- u[0]=0x7FFF, z[0]=0x8000 -> difference 65535 saturates, primal_res=0x7FFF.
- rd_valid delayed 3 cycles and wr_ready low 4 cycles at idx 5 -> operands latched only on rd_valid, wr_* stable while stalled, done delayed by exactly 7 cycles (edge 57).
- cmd_abort asserted during WAIT_DU of idx 2 -> IDLE next edge, no cmd_done, no write for idx 2, primal_res keeps its prior value. A subsequent cmd_start restarts at idx 0.
- Spurious du_done in IDLE or WAIT_RD, and cmd_start asserted while busy -> no state change and no extra du_start.
